// File: rtl/dlx_bus_pkg.sv
// Constants shared across the DLX byte bus: lane width, default receive
// depth and the pointer-width helper used by the byte FIFOs and the arbiter.
package dlx_bus_pkg;

  localparam int BYTE_W                = 8;
  localparam int RX_FIFO_DEPTH_DEFAULT = 4;

  // Index width for a power-of-two depth; never below 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: advances by one on inc and wraps modulo 2**PW.
module fifo_ptr #(
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= '0;
    else if (inc) ptr <= ptr + PW'(1);
  end

endmodule

// File: rtl/byte_rx_fifo.sv
// Byte receive FIFO for the DLX bus: first-word fall-through head, count,
// full and a sticky overflow flag that records dropped bytes.
module byte_rx_fifo
  import dlx_bus_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH_DEFAULT,
  parameter int W     = BYTE_W,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [W-1:0]  I,
  input  logic          STB,
  input  logic          RD,
  input  logic          CLR_OVF,
  output logic [W-1:0]  O,
  output logic          VALID,
  output logic          FULL,
  output logic [CW-1:0] COUNT,
  output logic          OVF
);

  localparam int PW = ptr_w(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count, count_nxt;
  logic                    ovf_q, ovf_nxt;
  logic                    empty, full;
  logic                    pop_acc, wr_acc, ovf_set;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop_acc = RD && !empty;
  assign wr_acc  = STB && (!full || pop_acc);
  assign ovf_set = STB && full && !pop_acc;

  fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk (CLK),
    .rst (RESET),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk (CLK),
    .rst (RESET),
    .inc (pop_acc),
    .ptr (rd_ptr)
  );

  // Storage needs no reset; the count gates everything that reads it.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr] <= I;
  end

  always_comb begin
    count_nxt = count + CW'(wr_acc) - CW'(pop_acc);
    ovf_nxt   = ovf_q;
    if (ovf_set)      ovf_nxt = 1'b1;
    else if (CLR_OVF) ovf_nxt = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
      ovf_q <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign O     = empty ? '0 : mem[rd_ptr];
  assign VALID = !empty;
  assign FULL  = full;
  assign COUNT = count;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_byte_rx_fifo.sv
// Directed bench for byte_rx_fifo with hand-computed expectations.
module tb_byte_rx_fifo;

  logic       CLK = 1'b0;
  logic       RESET, STB, RD, CLR_OVF;
  logic [7:0] I, O;
  logic       VALID, FULL, OVF;
  logic [2:0] COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  byte_rx_fifo dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .I       (I),
    .STB     (STB),
    .RD      (RD),
    .CLR_OVF (CLR_OVF),
    .O       (O),
    .VALID   (VALID),
    .FULL    (FULL),
    .COUNT   (COUNT),
    .OVF     (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".O"},     O,     32'h00);
    chk({tag, ".VALID"}, VALID, 32'd0);
    chk({tag, ".FULL"},  FULL,  32'd0);
    chk({tag, ".COUNT"}, COUNT, 32'd0);
    chk({tag, ".OVF"},   OVF,   32'd0);
  endtask

  task automatic push(input logic [7:0] b);
    I = b; STB = 1'b1;
    tick();
    STB = 1'b0;
  endtask

  logic [7:0] fill_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] drain_a[4] = '{8'h22, 8'h33, 8'h44, 8'h00};
  logic [7:0] drain_b[4] = '{8'h03, 8'h04, 8'h05, 8'h00};

  initial begin
    RESET = 1'b1; STB = 1'b0; RD = 1'b0; CLR_OVF = 1'b0; I = 8'h00;
    tick(); tick();
    chk_idle("rst");
    RESET = 1'b0;
    tick();
    chk_idle("rst_rel");

    // Fill in order
    for (int k = 0; k < 4; k++) push(fill_a[k]);
    chk("fill.FULL",  FULL,  32'd1);
    chk("fill.COUNT", COUNT, 32'd4);
    chk("fill.O",     O,     32'h11);

    // Overflow drops 0x55, sticky flag, set beats clear
    push(8'h55);
    chk("ovf.COUNT", COUNT, 32'd4);
    chk("ovf.OVF",   OVF,   32'd1);
    chk("ovf.O",     O,     32'h11);
    CLR_OVF = 1'b1;
    push(8'h66);
    chk("ovf_setwins", OVF, 32'd1);
    tick();
    CLR_OVF = 1'b0;
    chk("ovf_clr", OVF, 32'd0);

    // Drain: no 0x55/0x66 may appear
    RD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drain%0d.O", k), O, 32'(drain_a[k]));
    end
    RD = 1'b0;
    chk("drain.VALID", VALID, 32'd0);
    chk("drain.COUNT", COUNT, 32'd0);

    // Simultaneous STB/RD on empty: no pass-through, write only
    I = 8'hA0; STB = 1'b1; RD = 1'b1;
    tick();
    STB = 1'b0;
    chk("sim_e.COUNT", COUNT, 32'd1);
    chk("sim_e.O",     O,     32'hA0);
    tick();
    RD = 1'b0;
    chk("sim_e.pop", COUNT, 32'd0);

    // Simultaneous STB/RD on full
    for (int k = 1; k <= 4; k++) push(8'(k));
    I = 8'h05; STB = 1'b1; RD = 1'b1;
    tick();
    STB = 1'b0;
    chk("sim_f.COUNT", COUNT, 32'd4);
    chk("sim_f.O",     O,     32'h02);
    chk("sim_f.OVF",   OVF,   32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("sim_f.drain%0d", k), O, 32'(drain_b[k]));
    end
    RD = 1'b0;
    chk("sim_f.VALID", VALID, 32'd0);

    // Wrap-around: pointers go round twice
    for (int k = 0; k < 10; k++) begin
      push(8'(k));
      chk($sformatf("wrap%0d.COUNT1", k), COUNT, 32'd1);
      chk($sformatf("wrap%0d.O", k), O, 32'(k));
      RD = 1'b1;
      tick();
      RD = 1'b0;
      chk($sformatf("wrap%0d.COUNT0", k), COUNT, 32'd0);
    end

    // RD on empty is ignored
    RD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rd_empty%0d.COUNT", k), COUNT, 32'd0);
    end
    RD = 1'b0;
    chk("rd_empty.OVF", OVF, 32'd0);
    push(8'h7E);
    chk("rd_empty.w.COUNT", COUNT, 32'd1);
    chk("rd_empty.w.O",     O,     32'h7E);
    I = 8'h3C; STB = 1'b1; RD = 1'b1;
    tick();
    STB = 1'b0;
    chk("skew.COUNT", COUNT, 32'd1);
    chk("skew.O",     O,     32'h3C);
    tick();
    RD = 1'b0;
    chk("skew.empty", COUNT, 32'd0);

    // Asynchronous reset mid-stream with three bytes held
    push(8'hC1); push(8'hC2); push(8'hC3);
    chk("mid.COUNT", COUNT, 32'd3);
    #2 RESET = 1'b1;
    #1 chk_idle("async_rst");
    #1 RESET = 1'b0;
    tick();
    chk_idle("async_rel");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
